// File: rtl/gmux_rr_if.sv
// gmux_rr_if: bundle of the channel-side and consumer-side handshake signals
// of the round-robin arbitrating mux.
//
// Signals:
//   d        packed channel data, DWIDTH bits per channel
//   d_valid  per-channel valid, bit index = channel index
//   d_last   per-channel end-of-packet flag, qualified by d_valid
//   d_ready  per-channel accept from the mux (one-hot or zero)
//   z        registered output word
//   z_valid  output stage holds a beat
//   z_last   end-of-packet flag of the held beat
//   z_sel    channel index of the held beat
//   z_ready  consumer accept
//
// Modports:
//   master  the surrounding system (producers and consumer)
//   slave   the mux itself
interface gmux_rr_if #(
  parameter int DWIDTH   = 8,
  parameter int SELWIDTH = 2
);
  localparam int NUM_CH = 1 << SELWIDTH;

  logic [DWIDTH*NUM_CH-1:0] d;
  logic [NUM_CH-1:0]        d_valid;
  logic [NUM_CH-1:0]        d_last;
  logic [NUM_CH-1:0]        d_ready;
  logic [DWIDTH-1:0]        z;
  logic                     z_valid;
  logic                     z_last;
  logic [SELWIDTH-1:0]      z_sel;
  logic                     z_ready;

  modport master (
    output d, d_valid, d_last, z_ready,
    input  d_ready, z, z_valid, z_last, z_sel
  );

  modport slave (
    input  d, d_valid, d_last, z_ready,
    output d_ready, z, z_valid, z_last, z_sel
  );
endinterface

// File: rtl/gmux_rr.sv
// gmux_rr: round-robin arbitrating multiplexer with a registered output stage.
// Picks one of NUM_CH valid/ready channels per cycle; with LOCK_PKT set, a
// granted channel keeps the output until its last beat has been taken, so
// multi-beat packets stay contiguous.
//
// Parameters:
//   DWIDTH     data width per channel
//   SELWIDTH   channel index width (NUM_CH = 1 << SELWIDTH, derived)
//   BIGENDIAN  0: channel w at d[w*DWIDTH +: DWIDTH]
//              1: channel w at d[(NUM_CH-1-w)*DWIDTH +: DWIDTH]
//   LOCK_PKT   1: hold grant until last beat, 0: arbitrate every beat
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gmux_rr_if slave modport (channel inputs, registered z outputs)
module gmux_rr #(
  parameter int DWIDTH    = 8,
  parameter int SELWIDTH  = 2,
  parameter int BIGENDIAN = 0,
  parameter int LOCK_PKT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  gmux_rr_if.slave    bus
);
  localparam int NUM_CH = 1 << SELWIDTH;

  logic [DWIDTH-1:0]   words [NUM_CH];
  logic [SELWIDTH-1:0] ptr;
  logic [SELWIDTH-1:0] lock_ch;
  logic                lock;
  logic [SELWIDTH-1:0] gnt;
  logic [SELWIDTH-1:0] cand;
  logic                eligible;
  logic                load;

  for (genvar w = 0; w < NUM_CH; w++) begin : g_unpack
    if (BIGENDIAN != 0) begin : g_be
      assign words[w] = bus.d[(NUM_CH-1-w)*DWIDTH +: DWIDTH];
    end else begin : g_le
      assign words[w] = bus.d[w*DWIDTH +: DWIDTH];
    end
  end

  assign load = !bus.z_valid || bus.z_ready;

  // Search offsets from the farthest (NUM_CH, i.e. ptr itself) down to the
  // nearest (ptr+1), so the nearest valid channel is the one left in gnt.
  // The SELWIDTH-bit add makes the modulo wrap for free.
  always_comb begin
    gnt      = lock_ch;
    eligible = 1'b0;
    cand     = '0;
    if (lock) begin
      eligible = bus.d_valid[lock_ch];
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        cand = ptr + SELWIDTH'(k);
        if (bus.d_valid[cand]) begin
          gnt      = cand;
          eligible = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.d_ready = '0;
    if (rst_n && load && eligible) begin
      bus.d_ready[gnt] = 1'b1;
    end
  end

  // Output stage and arbitration state. Lock is only ever set when LOCK_PKT
  // is enabled, so with LOCK_PKT = 0 it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.z       <= '0;
      bus.z_valid <= 1'b0;
      bus.z_last  <= 1'b0;
      bus.z_sel   <= '0;
      ptr         <= '1;
      lock        <= 1'b0;
      lock_ch     <= '0;
    end else if (load) begin
      if (eligible) begin
        bus.z       <= words[gnt];
        bus.z_valid <= 1'b1;
        bus.z_last  <= bus.d_last[gnt];
        bus.z_sel   <= gnt;
        ptr         <= gnt;
        if (bus.d_last[gnt]) begin
          lock <= 1'b0;
        end else if (LOCK_PKT != 0) begin
          lock    <= 1'b1;
          lock_ch <= gnt;
        end
      end else begin
        bus.z_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gmux_rr.sv
// tb_gmux_rr: self-checking bench for gmux_rr. Four instances share one
// channel-level stimulus: little-endian locked, big-endian locked,
// little-endian unlocked, and a two-channel locked variant. A behavioural
// model per instance predicts d_ready before each edge and the z outputs
// after it; directed phases add fixed expectations for the key scenarios.
module tb_gmux_rr;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  gmux_rr_if #(.DWIDTH(8), .SELWIDTH(2)) b0 ();
  gmux_rr_if #(.DWIDTH(8), .SELWIDTH(2)) b1 ();
  gmux_rr_if #(.DWIDTH(8), .SELWIDTH(2)) b2 ();
  gmux_rr_if #(.DWIDTH(8), .SELWIDTH(1)) b3 ();

  gmux_rr #(.DWIDTH(8), .SELWIDTH(2), .BIGENDIAN(0), .LOCK_PKT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  gmux_rr #(.DWIDTH(8), .SELWIDTH(2), .BIGENDIAN(1), .LOCK_PKT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  gmux_rr #(.DWIDTH(8), .SELWIDTH(2), .BIGENDIAN(0), .LOCK_PKT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  gmux_rr #(.DWIDTH(8), .SELWIDTH(1), .BIGENDIAN(0), .LOCK_PKT(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  int checks = 0;
  int errors = 0;

  // channel-level stimulus
  logic [7:0] word [4];
  logic [3:0] valid;
  logic [3:0] last;
  logic       zr;

  // per-instance reference model
  int   nch   [4] = '{4, 4, 4, 2};
  bit   lockp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] mz [4];
  bit   mzv   [4];
  bit   mzl   [4];
  int   mzs   [4];
  int   mptr  [4];
  bit   mlock [4];
  int   mlch  [4];
  int   gExp  [4];

  task automatic expectEq(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, i, obs, exp);
    end
  endtask

  function automatic logic [31:0] obsReady(int i);
    case (i)
      0:       return 32'(b0.d_ready);
      1:       return 32'(b1.d_ready);
      2:       return 32'(b2.d_ready);
      default: return 32'(b3.d_ready);
    endcase
  endfunction

  function automatic logic [31:0] obsZ(int i);
    case (i)
      0:       return 32'(b0.z);
      1:       return 32'(b1.z);
      2:       return 32'(b2.z);
      default: return 32'(b3.z);
    endcase
  endfunction

  function automatic logic [31:0] obsZv(int i);
    case (i)
      0:       return 32'(b0.z_valid);
      1:       return 32'(b1.z_valid);
      2:       return 32'(b2.z_valid);
      default: return 32'(b3.z_valid);
    endcase
  endfunction

  function automatic logic [31:0] obsZl(int i);
    case (i)
      0:       return 32'(b0.z_last);
      1:       return 32'(b1.z_last);
      2:       return 32'(b2.z_last);
      default: return 32'(b3.z_last);
    endcase
  endfunction

  function automatic logic [31:0] obsZs(int i);
    case (i)
      0:       return 32'(b0.z_sel);
      1:       return 32'(b1.z_sel);
      2:       return 32'(b2.z_sel);
      default: return 32'(b3.z_sel);
    endcase
  endfunction

  function automatic void modelReset(int i);
    mz[i]    = 8'h00;
    mzv[i]   = 1'b0;
    mzl[i]   = 1'b0;
    mzs[i]   = 0;
    mptr[i]  = nch[i] - 1;
    mlock[i] = 1'b0;
    mlch[i]  = 0;
  endfunction

  // Who should be accepted this cycle: the locked channel only, otherwise
  // the first valid channel after the last one served, going around once.
  function automatic int modelGrant(int i);
    int c;
    if (!rst_n) return -1;
    if (mzv[i] && !zr) return -1;
    if (mlock[i]) return valid[mlch[i]] ? mlch[i] : -1;
    for (int k = 1; k <= nch[i]; k++) begin
      c = (mptr[i] + k) % nch[i];
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic void modelUpdate();
    int g;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        modelReset(i);
      end else if (!mzv[i] || zr) begin
        g = gExp[i];
        if (g >= 0) begin
          mz[i]   = word[g];
          mzl[i]  = last[g];
          mzs[i]  = g;
          mzv[i]  = 1'b1;
          mptr[i] = g;
          if (last[g]) begin
            mlock[i] = 1'b0;
          end else if (lockp[i]) begin
            mlock[i] = 1'b1;
            mlch[i]  = g;
          end
        end else begin
          mzv[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic driveBus();
    for (int w = 0; w < 4; w++) begin
      b0.d[w*8 +: 8]     = word[w];
      b1.d[(3-w)*8 +: 8] = word[w];
      b2.d[w*8 +: 8]     = word[w];
      if (w < 2) b3.d[w*8 +: 8] = word[w];
    end
    b0.d_valid = valid;       b0.d_last = last;       b0.z_ready = zr;
    b1.d_valid = valid;       b1.d_last = last;       b1.z_ready = zr;
    b2.d_valid = valid;       b2.d_last = last;       b2.z_ready = zr;
    b3.d_valid = valid[1:0];  b3.d_last = last[1:0];  b3.z_ready = zr;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 4; i++) begin
      expectEq("z_valid", i, obsZv(i), 32'(mzv[i]));
      expectEq("z",       i, obsZ(i),  32'(mz[i]));
      expectEq("z_last",  i, obsZl(i), 32'(mzl[i]));
      expectEq("z_sel",   i, obsZs(i), 32'(mzs[i]));
    end
  endtask

  // One clock cycle: drive at the falling edge, check d_ready against the
  // model, take the rising edge, then check the registered outputs.
  task automatic applyStimulus();
    logic [31:0] expRdy;
    @(negedge clk);
    driveBus();
    #1;
    for (int i = 0; i < 4; i++) begin
      gExp[i] = modelGrant(i);
      expRdy  = (gExp[i] >= 0) ? (32'd1 << gExp[i]) : 32'd0;
      expectEq("d_ready", i, obsReady(i), expRdy);
    end
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  task automatic randWords();
    for (int w = 0; w < 4; w++) word[w] = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) modelReset(i);
    for (int w = 0; w < 4; w++) word[w] = 8'(((w + 1) << 4) | w);
    valid = 4'b1111;
    last  = 4'b1111;
    zr    = 1'b1;
    rst_n = 1'b0;

    // reset held for two cycles with every channel valid
    repeat (2) begin
      applyStimulus();
      expectEq("rst_ready", 0, obsReady(0), 32'd0);
      expectEq("rst_zvalid", 0, obsZv(0), 32'd0);
      expectEq("rst_z", 1, obsZ(1), 32'd0);
    end

    // round-robin fairness with single-beat packets
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus();
      expectEq("fair_sel", 0, obsZs(0), 32'(k % 4));
      expectEq("fair_z",   0, obsZ(0),  32'(((k % 4 + 1) << 4) | (k % 4)));
      expectEq("fair_z",   1, obsZ(1),  32'(((k % 4 + 1) << 4) | (k % 4)));
      expectEq("fair_sel", 3, obsZs(3), 32'(k % 2));
    end

    // packet lock: ch2 sends three beats while the others stay valid
    randWords();
    valid = 4'b0100; last = 4'b1011;
    applyStimulus();
    expectEq("lock_sel", 0, obsZs(0), 32'd2);
    expectEq("lock_last", 0, obsZl(0), 32'd0);
    expectEq("nolock_sel", 2, obsZs(2), 32'd2);
    randWords();
    valid = 4'b1111; last = 4'b1011;
    applyStimulus();
    expectEq("lock_sel", 0, obsZs(0), 32'd2);
    expectEq("lock_last", 0, obsZl(0), 32'd0);
    expectEq("nolock_sel", 2, obsZs(2), 32'd3);
    randWords();
    last = 4'b1111;
    applyStimulus();
    expectEq("lock_sel", 0, obsZs(0), 32'd2);
    expectEq("lock_last", 0, obsZl(0), 32'd1);
    expectEq("nolock_sel", 2, obsZs(2), 32'd0);
    randWords();
    applyStimulus();
    expectEq("lock_sel", 0, obsZs(0), 32'd3);
    expectEq("nolock_sel", 2, obsZs(2), 32'd1);

    // backpressure: output stalls for five cycles, nothing accepted
    zr = 1'b0;
    repeat (5) begin
      randWords();
      applyStimulus();
      expectEq("stall_ready", 0, obsReady(0), 32'd0);
      expectEq("stall_sel", 0, obsZs(0), 32'd3);
      expectEq("stall_valid", 0, obsZv(0), 32'd1);
    end
    zr = 1'b1;
    applyStimulus();
    expectEq("resume_sel", 0, obsZs(0), 32'd0);

    // lock starvation: ch1 locked, then goes quiet while ch0 waits
    randWords();
    valid = 4'b0010; last = 4'b0000;
    applyStimulus();
    expectEq("starve_lock_sel", 0, obsZs(0), 32'd1);
    valid = 4'b0001; last = 4'b0001;
    repeat (4) begin
      randWords();
      applyStimulus();
      expectEq("starve_valid", 0, obsZv(0), 32'd0);
      expectEq("starve_ready", 0, obsReady(0), 32'd0);
    end
    randWords();
    valid = 4'b0011; last = 4'b0011;
    applyStimulus();
    expectEq("resume_lock_sel", 0, obsZs(0), 32'd1);
    expectEq("resume_lock_last", 0, obsZl(0), 32'd1);
    valid = 4'b0001;
    applyStimulus();
    expectEq("after_lock_sel", 0, obsZs(0), 32'd0);
    valid = 4'b0000;
    applyStimulus();
    expectEq("idle_valid", 0, obsZv(0), 32'd0);

    // reset in the middle of a ch3 packet
    randWords();
    valid = 4'b1000; last = 4'b0000;
    applyStimulus();
    expectEq("mid_lock_sel", 0, obsZs(0), 32'd3);
    rst_n = 1'b0;
    applyStimulus();
    expectEq("mid_rst_valid", 0, obsZv(0), 32'd0);
    rst_n = 1'b1;
    valid = 4'b1001; last = 4'b1001;
    applyStimulus();
    expectEq("post_rst_sel", 0, obsZs(0), 32'd0);

    // randomized traffic with occasional stalls and resets
    for (int n = 0; n < 600; n++) begin
      randWords();
      valid = 4'($urandom_range(0, 15));
      last  = 4'($urandom);
      zr    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gmux_rr.md
# gmux_rr

Round-robin arbitrating multiplexer: the sequential successor to the combinational word mux. It selects one of `NUM_CH` valid/ready input channels per cycle into a single registered output stage. Packet lock keeps multi-beat transfers contiguous. It sits between per-channel producers (encoder, ADC, telemetry framers) and a shared single-consumer path such as the host link FIFO.

## Interface
- `DWIDTH`, 8: data word width per channel.
- `SELWIDTH`, 2: channel index width.
- `NUM_CH`, `1 << SELWIDTH`: channel count; derived, do not override.
- `BIGENDIAN`, 0:
  - 0: channel w occupies `d[w*DWIDTH +: DWIDTH]`.
  - 1: channel w occupies `d[(NUM_CH-1-w)*DWIDTH +: DWIDTH]`.
- `LOCK_PKT`, 1:
  - 1: a granted channel holds the output until its `last` beat is accepted.
  - 0: arbitration happens on every beat.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `d` in `DWIDTH*NUM_CH`: packed channel data, ordered per `BIGENDIAN`.
- `d_valid` in `NUM_CH`: per-channel valid, bit index = channel index (unaffected by `BIGENDIAN`).
- `d_last` in `NUM_CH`: per-channel end-of-packet flag, qualified by `d_valid`.
- `d_ready` out `NUM_CH`: per-channel accept, one-hot or zero.
- `z` out `DWIDTH`: registered output data.
- `z_valid` out 1: output holds a beat.
- `z_last` out 1: registered `last` of the held beat.
- `z_sel` out `SELWIDTH`: channel index of the held beat.
- `z_ready` in 1: consumer accepts the beat when `z_valid && z_ready`.

## Operation
- `load = !z_valid || z_ready` (output stage empty or draining this cycle).
- Arbitration is combinational from the registered state `ptr` (last granted channel) and `lock` / `lock_ch`:
  - if `lock`: `gnt = lock_ch`, eligible only if `d_valid[lock_ch]`.
  - else: `gnt` = first channel with `d_valid` set, searching `ptr+1, ptr+2, …` modulo `NUM_CH`.
  - if nothing is eligible, there is no grant.
- `d_ready[gnt] = load && eligible`; all other bits of `d_ready` are 0.
  - `d_ready` never depends on `d_valid` of other channels while locked.
- Transfer in (`load && eligible`):
  - `z <= word(gnt)`, `z_last <= d_last[gnt]`, `z_sel <= gnt`, `z_valid <= 1`, `ptr <= gnt`.
  - If `LOCK_PKT` and `!d_last[gnt]`: `lock <= 1`, `lock_ch <= gnt`.
  - If `d_last[gnt]`: `lock <= 0`.
- `load` with no eligible channel: `z_valid <= 0`; `z`, `z_last` and `z_sel` hold their values.
- `!load` (output stalled): all output registers hold; `d_ready` is all zero.
- Locked channel drops `d_valid` mid-packet: output empties when drained, lock stays set, and other channels stay blocked until `lock_ch` resumes and sends `last`.
- `LOCK_PKT = 0`: `lock` is tied to 0 and `d_last` is only passed through to `z_last`.
- `NUM_CH = 2` (`SELWIDTH = 1`) must work; the modulo search wraps naturally through the `SELWIDTH`-bit counter.

## Timing
- Latency: input handshake at edge N puts the beat on `z` / `z_valid` after edge N.
- Throughput: one beat per cycle when `z_ready` is held high. There is no bubble on channel switch or on lock release.
- `d_ready` is combinational from `z_valid`, `z_ready`, `d_valid`, `ptr` and `lock`. `z*` outputs are registered only.
- Reset (`rst_n` low at a rising edge), taking effect at that edge:
  - `z_valid = 0`, `z = 0`, `z_last = 0`, `z_sel = 0`.
  - `ptr = NUM_CH-1`, so channel 0 has first priority.
  - `lock = 0`, `lock_ch = 0`.
  - `d_ready` is forced to 0 while `rst_n` is low.
  - A reset mid-packet discards the held beat and the lock.
- Simultaneous `z_ready` acceptance and new grant in the same cycle is a legal load; the new beat replaces the old with no gap.

## Test plan
- **Reset:** `rst_n` low for 2 cycles with all `d_valid = 1111` → `d_ready = 0000`, `z_valid = 0`, `z = 0`. First edge after release accepts channel 0, `z_sel = 0`.
- **Round-robin fairness:** `DWIDTH = 8`, `d_valid = 1111` with single-beat packets and `z_ready = 1` for 8 cycles → `z_sel` sequence is 0,1,2,3,0,1,2,3. Data equals per-channel words 0x10/0x21/0x32/0x43, checked with `BIGENDIAN` = 0 and 1.
- **Packet lock:** ch2 sends 3 beats (`last` on beat 3) while ch0/ch1/ch3 stay valid → three consecutive `z_sel = 2`, `z_last` pattern 0,0,1, then `z_sel = 3`. Repeat with `LOCK_PKT = 0` → `z_sel` interleaves 2,3,0,1.
- **Backpressure:** `z_ready = 0` for 5 cycles with `z_valid = 1` → `z`, `z_sel` and `z_last` stable and `d_ready = 0000`. On `z_ready = 1`, the next beat appears the following cycle without loss or duplication.
- **Lock starvation and idle:** ch1 locked, drops `d_valid` for 4 cycles while ch0 is valid → `z_valid` falls after drain and ch0 is not granted. ch1 resumes with `last` → ch1 beat out, then ch0. With all `d_valid = 0`, `z_valid` returns to 0 one cycle after the last acceptance.
- **Reset mid-packet:** ch3 locked after 1 of 3 beats, assert `rst_n` low for 1 cycle → `z_valid = 0`, lock cleared. After release with `d_valid = 1001`, channel 0 is granted first.
